// File: rtl/carrier_loop_nco.sv
// rtl/carrier_loop_nco.sv - integrate-and-dump PI carrier loop driving a wrapping NCO, with ACQ/TRACK lock detect.
// Optional macro LOOP_FREQ_LIMIT_EN clamps the frequency integrator (and its clr load) to +/-FREQ_LIM.
module carrier_loop_nco #(
    parameter int EW         = 16,
    parameter int CW         = 16,
    parameter int PW         = 24,
    parameter int FRAC       = 14,
    parameter int DEC_LOG2   = 2,
    parameter int LOCK_THR   = 256,
    parameter int LOCK_N     = 4,
    parameter int UNLOCK_THR = 1024,
    parameter int UNLOCK_N   = 2
`ifdef LOOP_FREQ_LIMIT_EN
    ,
    parameter int FREQ_LIM   = 2 ** (PW - 2)
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [PW-1:0] freq_init,
    input  logic [EW-1:0] err_in,
    input  logic          err_valid,
    input  logic [CW-1:0] kp_acq,
    input  logic [CW-1:0] ki_acq,
    input  logic [CW-1:0] kp_trk,
    input  logic [CW-1:0] ki_trk,
    output logic [PW-1:0] nco_phase,
    output logic [PW-1:0] freq_word,
    output logic [EW-1:0] err_avg,
    output logic          upd_valid,
    output logic          locked
);
    localparam int AW   = EW + DEC_LOG2;
    localparam int PRW  = EW + CW + 1;
    localparam int WW   = ((PRW > PW) ? PRW : PW) + 2;
    localparam int CNTW = $clog2(((LOCK_N > UNLOCK_N) ? LOCK_N : UNLOCK_N) + 1);

    localparam logic [DEC_LOG2-1:0] BLK_LAST  = '1;
    localparam logic [CNTW-1:0]     HIT_LAST  = CNTW'(LOCK_N - 1);
    localparam logic [CNTW-1:0]     MISS_LAST = CNTW'(UNLOCK_N - 1);
    localparam logic [EW:0]         LOCK_T    = (EW + 1)'(LOCK_THR);
    localparam logic [EW:0]         UNLOCK_T  = (EW + 1)'(UNLOCK_THR);
    localparam logic signed [WW-1:0] PW_MAX   = {{(WW - PW + 1){1'b0}}, {(PW - 1){1'b1}}};
`ifdef LOOP_FREQ_LIMIT_EN
    localparam logic signed [WW-1:0] FW_LIM   = WW'(FREQ_LIM);
`else
    localparam logic signed [WW-1:0] FW_LIM   = PW_MAX;
`endif

    typedef enum logic {ACQ, TRACK} state_t;

    state_t state, state_n;
    logic [CNTW-1:0] hit_cnt, hit_n, miss_cnt, miss_n;

    logic signed [AW-1:0]  acc, dump, acc_sum, dump_sh;
    logic [DEC_LOG2-1:0]   cnt;
    logic                  v1, v2;
    logic signed [EW-1:0]  e1, e_r;
    logic signed [PRW-1:0] e_x, kp_x, ki_x, p_prod, i_prod, p_r, i_r, p_sh, i_sh;
    logic [CW-1:0]         kp_sel, ki_sel;
    logic [PW-1:0]         p_step, phase_next, fw_next, fw_init;
    logic [EW-1:0]         abs_e;
    logic                  lock_hit, unlock_miss;

    // Symmetric saturation; returns the low PW bits of the clamped value.
    function automatic logic [PW-1:0] clamp(input logic signed [WW-1:0] v,
                                            input logic signed [WW-1:0] lim);
        logic signed [WW-1:0] r;
        r = v;
        if (v > lim) r = lim;
        else if (v < -lim) r = -lim;
        return r[PW-1:0];
    endfunction

    assign acc_sum = acc + {{DEC_LOG2{err_in[EW-1]}}, err_in};
    assign dump_sh = dump >>> DEC_LOG2;

    always_comb begin
        e1 = dump_sh[EW-1:0];
        if (dump_sh[AW-1:EW-1] != '0 && dump_sh[AW-1:EW-1] != '1)
            e1 = dump_sh[AW-1] ? {1'b1, {(EW - 1){1'b0}}} : {1'b0, {(EW - 1){1'b1}}};
    end

    assign kp_sel = (state == TRACK) ? kp_trk : kp_acq;
    assign ki_sel = (state == TRACK) ? ki_trk : ki_acq;
    assign e_x    = PRW'(e1);
    assign kp_x   = PRW'({1'b0, kp_sel});
    assign ki_x   = PRW'({1'b0, ki_sel});
    assign p_prod = e_x * kp_x;
    assign i_prod = e_x * ki_x;

    assign p_sh       = p_r >>> FRAC;
    assign i_sh       = i_r >>> FRAC;
    assign p_step     = clamp(WW'(p_sh), PW_MAX);
    assign phase_next = nco_phase + p_step + freq_word;
    assign fw_next    = clamp(WW'($signed(freq_word)) + WW'(i_sh), FW_LIM);
`ifdef LOOP_FREQ_LIMIT_EN
    assign fw_init    = clamp(WW'($signed(freq_init)), FW_LIM);
`else
    assign fw_init    = freq_init;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc       <= '0;
            cnt       <= '0;
            dump      <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            e_r       <= '0;
            p_r       <= '0;
            i_r       <= '0;
            nco_phase <= '0;
            err_avg   <= '0;
            upd_valid <= 1'b0;
            freq_word <= rst ? '0 : fw_init;
        end else begin
            v1        <= 1'b0;
            v2        <= v1;
            upd_valid <= v2;
            if (err_valid) begin
                if (cnt == BLK_LAST) begin
                    dump <= acc_sum;
                    v1   <= 1'b1;
                    acc  <= '0;
                    cnt  <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end
            end
            if (v1) begin
                e_r <= e1;
                p_r <= p_prod;
                i_r <= i_prod;
            end
            if (v2) begin
                nco_phase <= phase_next;
                freq_word <= fw_next;
                err_avg   <= e_r;
            end
        end
    end

    // Two's-complement negate of the most negative value reads as 2^(EW-1) unsigned.
    assign abs_e       = e_r[EW-1] ? -e_r : e_r;
    assign lock_hit    = {1'b0, abs_e} < LOCK_T;
    assign unlock_miss = {1'b0, abs_e} >= UNLOCK_T;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state    <= ACQ;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_n;
            hit_cnt  <= hit_n;
            miss_cnt <= miss_n;
        end
    end

    always_comb begin
        state_n = state;
        hit_n   = hit_cnt;
        miss_n  = miss_cnt;
        if (v2) begin
            case (state)
                ACQ: begin
                    if (lock_hit) begin
                        if (hit_cnt == HIT_LAST) begin
                            state_n = TRACK;
                            hit_n   = '0;
                            miss_n  = '0;
                        end else begin
                            hit_n = hit_cnt + 1'b1;
                        end
                    end else begin
                        hit_n = '0;
                    end
                end
                TRACK: begin
                    if (unlock_miss) begin
                        if (miss_cnt == MISS_LAST) begin
                            state_n = ACQ;
                            hit_n   = '0;
                            miss_n  = '0;
                        end else begin
                            miss_n = miss_cnt + 1'b1;
                        end
                    end else begin
                        miss_n = '0;
                    end
                end
                default: state_n = ACQ;
            endcase
        end
    end

    assign locked = (state == TRACK);
endmodule

// File: tb/tb_carrier_loop_nco.sv
// tb/tb_carrier_loop_nco.sv - randomized bench for carrier_loop_nco against an arithmetic loop model.
module tb_carrier_loop_nco;
`ifdef LOOP_FREQ_LIMIT_EN
    localparam longint FW_MAX = 1000;
`else
    localparam longint FW_MAX = (longint'(1) << 23) - 1;
`endif
    localparam longint PMASK = (longint'(1) << 24) - 1;

    logic        clk = 0;
    logic        rst = 1;
    logic        clr = 0;
    logic [23:0] freq_init = 0;
    logic [15:0] err_in = 0;
    logic        err_valid = 0;
    logic [15:0] kp_acq = 0, ki_acq = 0, kp_trk = 0, ki_trk = 0;
    logic [23:0] nco_phase, freq_word;
    logic [15:0] err_avg;
    logic        upd_valid, locked;

    int passed = 0;
    int total  = 0;
    bit chk_en = 0;

    // Loop model state
    longint m_phase, m_fw, m_sum, px_phase, px_fw, px_e, x_phase, x_fw, x_e;
    int     m_cnt, m_pend, m_hit, m_miss;
    bit     m_trk, px_lock, x_lock, exp_upd;

`ifdef LOOP_FREQ_LIMIT_EN
    carrier_loop_nco #(.FREQ_LIM(1000)) dut (
`else
    carrier_loop_nco dut (
`endif
        .clk(clk), .rst(rst), .clr(clr), .freq_init(freq_init),
        .err_in(err_in), .err_valid(err_valid),
        .kp_acq(kp_acq), .ki_acq(ki_acq), .kp_trk(kp_trk), .ki_trk(ki_trk),
        .nco_phase(nco_phase), .freq_word(freq_word), .err_avg(err_avg),
        .upd_valid(upd_valid), .locked(locked)
    );

    always #5 clk = ~clk;

    function automatic longint clampl(input longint v, input longint lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // Monitor: at each negedge, check what the previous edge produced, then model the next edge.
    initial begin
        m_phase = 0; m_fw = 0; m_sum = 0; m_cnt = 0; m_pend = 0; m_hit = 0; m_miss = 0; m_trk = 0;
        exp_upd = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                total++;
                if (upd_valid !== exp_upd)
                    $display("FAIL upd_valid t=%0t got=%b exp=%b", $time, upd_valid, exp_upd);
                else passed++;
                if (exp_upd) begin
                    total++;
                    if (nco_phase !== x_phase[23:0] || freq_word !== x_fw[23:0] ||
                        err_avg !== x_e[15:0] || locked !== x_lock)
                        $display("FAIL update t=%0t got ph=%0d fw=%0d e=%0d lk=%b exp ph=%0d fw=%0d e=%0d lk=%b",
                                 $time, nco_phase, $signed(freq_word), $signed(err_avg), locked,
                                 x_phase, x_fw, x_e, x_lock);
                    else passed++;
                end
            end
            exp_upd = 0;
            if (rst || clr) begin
                m_phase = 0; m_sum = 0; m_cnt = 0; m_pend = 0; m_hit = 0; m_miss = 0; m_trk = 0;
`ifdef LOOP_FREQ_LIMIT_EN
                m_fw = rst ? 0 : clampl(longint'($signed(freq_init)), FW_MAX);
`else
                m_fw = rst ? 0 : longint'($signed(freq_init));
`endif
            end else begin
                if (m_pend > 0) begin
                    m_pend--;
                    if (m_pend == 0) begin
                        exp_upd = 1;
                        x_phase = px_phase; x_fw = px_fw; x_e = px_e; x_lock = px_lock;
                    end
                end
                if (err_valid) begin
                    m_sum += longint'($signed(err_in));
                    m_cnt++;
                    if (m_cnt == 4) begin
                        longint e, kp, ki, mag;
                        e  = clampl(m_sum >>> 2, 32767);
                        kp = m_trk ? longint'(kp_trk) : longint'(kp_acq);
                        ki = m_trk ? longint'(ki_trk) : longint'(ki_acq);
                        m_phase = (m_phase + clampl((e * kp) >>> 14, (longint'(1) << 23) - 1) + m_fw) & PMASK;
                        m_fw = clampl(m_fw + ((e * ki) >>> 14), FW_MAX);
                        mag = (e < 0) ? -e : e;
                        if (!m_trk) begin
                            if (mag < 256) begin
                                m_hit++;
                                if (m_hit == 4) begin m_trk = 1; m_hit = 0; m_miss = 0; end
                            end else m_hit = 0;
                        end else begin
                            if (mag >= 1024) begin
                                m_miss++;
                                if (m_miss == 2) begin m_trk = 0; m_hit = 0; m_miss = 0; end
                            end else m_miss = 0;
                        end
                        px_phase = m_phase; px_fw = m_fw; px_e = e; px_lock = m_trk;
                        m_sum = 0; m_cnt = 0; m_pend = 2;
                    end
                end
            end
        end
    end

    task automatic drive(input bit v, input int e, input bit c);
        err_valid = v;
        err_in    = 16'(e);
        clr       = c;
        @(posedge clk);
        #1;
        err_valid = 0;
        clr       = 0;
    endtask

    task automatic run(input int n, input int e);
        for (int i = 0; i < n; i++) drive(1, e, 0);
        repeat (4) drive(0, 0, 0);
    endtask

    task automatic soft_clear(input int fi);
        freq_init = 24'(fi);
        drive(0, 0, 1);
    endtask

    task automatic test_reset;
        rst = 0;
        kp_acq = 16384; ki_acq = 16384;
        for (int i = 0; i < 9; i++) drive(1, 700, 0);
        rst = 1;
        err_valid = 1; err_in = 16'd1234;
        repeat (3) @(posedge clk);
        #1;
        rst = 0; err_valid = 0;
        total++; if (nco_phase !== 0) $display("FAIL rst_phase got=%0d exp=0", nco_phase); else passed++;
        total++; if (freq_word !== 0) $display("FAIL rst_freq got=%0d exp=0", freq_word); else passed++;
        total++; if (err_avg !== 0) $display("FAIL rst_err_avg got=%0d exp=0", err_avg); else passed++;
        total++; if (upd_valid !== 0) $display("FAIL rst_upd got=%b exp=0", upd_valid); else passed++;
        total++; if (locked !== 0) $display("FAIL rst_locked got=%b exp=0", locked); else passed++;
        chk_en = 1;
        ki_acq = 0;
        run(4, 1000);
        total++; if (nco_phase !== 24'd1000) $display("FAIL rst_fresh_block got=%0d exp=1000", nco_phase); else passed++;
    endtask

    task automatic test_proportional;
        soft_clear(0);
        kp_acq = 16384; ki_acq = 0;
        run(12, 1000);
        total++; if (nco_phase !== 24'd3000) $display("FAIL prop_phase got=%0d exp=3000", nco_phase); else passed++;
        total++; if (freq_word !== 0) $display("FAIL prop_freq got=%0d exp=0", freq_word); else passed++;
        total++; if (err_avg !== 16'd1000) $display("FAIL prop_err_avg got=%0d exp=1000", err_avg); else passed++;
    endtask

    task automatic test_integral;
        soft_clear(0);
        kp_acq = 0; ki_acq = 16384;
        run(12, 100);
        total++; if (freq_word !== 24'd300) $display("FAIL int_freq got=%0d exp=300", freq_word); else passed++;
        total++; if (nco_phase !== 24'd300) $display("FAIL int_phase got=%0d exp=300", nco_phase); else passed++;
    endtask

    task automatic test_wrap;
        soft_clear(0);
        kp_acq = 16384; ki_acq = 0;
        run(513 * 4, 32767);
        total++; if (nco_phase !== 24'd32255) $display("FAIL wrap_phase got=%0d exp=32255", nco_phase); else passed++;
    endtask

    task automatic test_lock;
        soft_clear(0);
        kp_acq = 16384; kp_trk = 4096; ki_acq = 0; ki_trk = 0;
        run(16, 100);
        total++; if (locked !== 1) $display("FAIL lock_rise got=%b exp=1", locked); else passed++;
        run(20, 500);
        total++; if (locked !== 1) $display("FAIL lock_hold got=%b exp=1", locked); else passed++;
        run(8, 2000);
        total++; if (locked !== 0) $display("FAIL lock_fall got=%b exp=0", locked); else passed++;
    endtask

    task automatic test_clr;
        longint fexp;
        soft_clear(0);
        kp_acq = 16384; ki_acq = 0;
        drive(1, 1000, 0);
        drive(1, 1000, 0);
        freq_init = 24'd5000;
        drive(1, 1000, 1);
        fexp = (5000 > FW_MAX) ? FW_MAX : 5000;
        total++; if (freq_word !== fexp[23:0]) $display("FAIL clr_freq got=%0d exp=%0d", freq_word, fexp); else passed++;
        total++; if (nco_phase !== 0 || locked !== 0) $display("FAIL clr_state got ph=%0d lk=%b exp 0 0", nco_phase, locked); else passed++;
        run(3, 1000);
        total++; if (nco_phase !== 0) $display("FAIL clr_drop got=%0d exp=0", nco_phase); else passed++;
        run(1, 1000);
        fexp = fexp + 1000;
        total++; if (nco_phase !== fexp[23:0]) $display("FAIL clr_first_upd got=%0d exp=%0d", nco_phase, fexp); else passed++;
    endtask

`ifdef LOOP_FREQ_LIMIT_EN
    task automatic test_limit;
        soft_clear(0);
        kp_acq = 0; ki_acq = 16384;
        run(16, 400);
        total++; if (freq_word !== 24'd1000) $display("FAIL limit_freq got=%0d exp=1000", freq_word); else passed++;
    endtask
`endif

    task automatic test_random;
        for (int seg = 0; seg < 6; seg++) begin
            kp_acq = 16'($urandom); ki_acq = 16'($urandom_range(8192));
            kp_trk = 16'($urandom); ki_trk = 16'($urandom_range(8192));
            if (seg == 0) soft_clear(int'($urandom_range(8000000)) - 4000000);
            for (int i = 0; i < 700; i++) begin
                int mode, e;
                mode = (i / 80 + seg) % 3;
                if (mode == 0) e = int'($urandom_range(400)) - 200;
                else if (mode == 1) e = int'($urandom_range(1600)) - 800;
                else e = int'($urandom_range(65535)) - 32768;
                if ($urandom_range(499) == 0) begin
                    freq_init = 24'($urandom_range(8000000) - 4000000);
                    drive($urandom_range(1), e, 1);
                end else begin
                    drive($urandom_range(3) != 0, e, 0);
                end
            end
            repeat (5) drive(0, 0, 0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_proportional;
        test_integral;
        test_wrap;
        test_lock;
        test_clr;
`ifdef LOOP_FREQ_LIMIT_EN
        test_limit;
`endif
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
